// File: rtl/cu_pkg.sv
// Shared types and constants for the cu_seq control sequencer: opcode encodings,
// FSM states, ALU/writeback selects and the decoded control word.
package cu_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000101;
  localparam logic [5:0] OP_MUL  = 6'b000110;
  localparam logic [5:0] OP_LDIM = 6'b001110;
  localparam logic [5:0] OP_CLR  = 6'b001111;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    IT_NONE  = 2'b00,
    IT_RTYPE = 2'b01,
    IT_IMM   = 2'b10
  } inst_type_t;

  typedef enum logic [2:0] {
    WB_ALU = 3'b000,
    WB_IMM = 3'b001
  } wb_sel_t;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       alu_c_in;
    inst_type_t inst_type;
    wb_sel_t    wb_sel;
    logic       is_rtype;
    logic       is_multi;
    logic       is_ldim;
    logic       is_clr;
    logic       is_hlt;
    logic       is_illegal;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '{
    alu_sel:    4'b0000,
    alu_c_in:   1'b0,
    inst_type:  IT_NONE,
    wb_sel:     WB_ALU,
    is_rtype:   1'b0,
    is_multi:   1'b0,
    is_ldim:    1'b0,
    is_clr:     1'b0,
    is_hlt:     1'b0,
    is_illegal: 1'b0
  };

  function automatic ctrl_word_t rtype_ctrl(input logic [3:0] sel, input logic c_in,
                                            input logic multi);
    ctrl_word_t w;
    w           = CTRL_NOP;
    w.alu_sel   = sel;
    w.alu_c_in  = c_in;
    w.inst_type = IT_RTYPE;
    w.wb_sel    = WB_ALU;
    w.is_rtype  = 1'b1;
    w.is_multi  = multi;
    return w;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Purely combinational opcode decoder: maps a (zero-extended) opcode to the
// sequencer's control word. Anything not listed is flagged illegal and treated as NOP.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output ctrl_word_t          o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_NOP;
    case (i_opcode)
      OPCODE_W'(OP_ADD):  o_ctrl = rtype_ctrl(ALU_ADD, 1'b0, 1'b0);
      OPCODE_W'(OP_SUB):  o_ctrl = rtype_ctrl(ALU_SUB, 1'b1, 1'b0);
      OPCODE_W'(OP_AND):  o_ctrl = rtype_ctrl(ALU_AND, 1'b0, 1'b0);
      OPCODE_W'(OP_OR):   o_ctrl = rtype_ctrl(ALU_OR,  1'b0, 1'b0);
      OPCODE_W'(OP_XOR):  o_ctrl = rtype_ctrl(ALU_XOR, 1'b0, 1'b0);
      OPCODE_W'(OP_MUL):  o_ctrl = rtype_ctrl(ALU_MUL, 1'b0, 1'b1);
      OPCODE_W'(OP_LDIM): begin
        o_ctrl.inst_type = IT_IMM;
        o_ctrl.wb_sel    = WB_IMM;
        o_ctrl.is_ldim   = 1'b1;
      end
      OPCODE_W'(OP_CLR):  o_ctrl.is_clr = 1'b1;
      OPCODE_W'(OP_HLT):  o_ctrl.is_hlt = 1'b1;
      OPCODE_W'(OP_NOP):  o_ctrl = CTRL_NOP;
      default:            o_ctrl.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle control sequencer FETCH -> DECODE -> EXEC -> WB with a MUL timeout.
// Optional macro CU_ILLEGAL_TRAP_EN adds a sticky TRAP state and the illegal_op output.
module cu_seq
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_SEL_W   = 4,
  parameter int WB_SEL_W    = 3,
  parameter int MUL_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 alu_done,
  output logic                 alu_c_in,
  output logic                 alu_enable,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 reg_read_a,
  output logic                 reg_read_b,
  output logic                 reg_write,
  output logic                 reg_reset,
  output logic [1:0]           inst_type,
  output logic [WB_SEL_W-1:0]  wb_sel,
  output logic                 pc_inc,
  output logic                 busy,
  output logic                 halted,
  output logic                 exec_timeout
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_op
`endif
);

  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

  state_t              r_state;
  logic [OPCODE_W-1:0] r_opcode;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_timeout;
  ctrl_word_t          w_ctrl;

  cu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .i_opcode (r_opcode),
    .o_ctrl   (w_ctrl)
  );

  // FSM: phase sequencing, opcode latch and MUL wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_opcode  <= OPCODE_W'(OP_NOP);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        FETCH: begin
          r_cnt <= '0;
          if (instr_valid) begin
            r_opcode <= opcode;
            r_state  <= DECODE;
          end else begin
            r_state  <= FETCH;
          end
        end
        DECODE: begin
          if (w_ctrl.is_hlt) begin
            r_state <= HALT;
          end else if (w_ctrl.is_rtype) begin
            r_state <= EXEC;
`ifdef CU_ILLEGAL_TRAP_EN
          end else if (w_ctrl.is_illegal) begin
            r_state <= TRAP;
`else
          end else if (w_ctrl.is_illegal) begin
            r_state <= WB;
`endif
          end else begin
            r_state <= WB;
          end
        end
        EXEC: begin
          // a completing alu_done takes priority over the timeout in the same cycle
          if (!w_ctrl.is_multi || alu_done) begin
            r_state <= WB;
          end else if (r_cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
            r_state   <= FETCH;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WB:      r_state <= FETCH;
        HALT:    r_state <= HALT;
        TRAP:    r_state <= TRAP;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Phase gating: every output decoded from the registered state and opcode
  always_comb begin
    instr_ready  = 1'b0;
    alu_c_in     = 1'b0;
    alu_enable   = 1'b0;
    alu_sel      = '0;
    reg_read_a   = 1'b0;
    reg_read_b   = 1'b0;
    reg_write    = 1'b0;
    reg_reset    = 1'b0;
    inst_type    = 2'b00;
    wb_sel       = '0;
    pc_inc       = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    exec_timeout = 1'b0;
    case (r_state)
      FETCH: begin
        instr_ready  = 1'b1;
        exec_timeout = r_timeout;
      end
      DECODE: begin
        busy       = 1'b1;
        reg_read_a = w_ctrl.is_rtype;
        reg_read_b = w_ctrl.is_rtype;
      end
      EXEC: begin
        busy       = 1'b1;
        alu_enable = 1'b1;
        alu_sel    = ALU_SEL_W'(w_ctrl.alu_sel);
        alu_c_in   = w_ctrl.alu_c_in;
        inst_type  = w_ctrl.inst_type;
        reg_read_a = 1'b1;
        reg_read_b = 1'b1;
      end
      WB: begin
        busy      = 1'b1;
        pc_inc    = 1'b1;
        reg_write = w_ctrl.is_rtype | w_ctrl.is_ldim;
        reg_reset = w_ctrl.is_clr;
        inst_type = w_ctrl.inst_type;
        wb_sel    = WB_SEL_W'(w_ctrl.wb_sel);
      end
      HALT:    halted = 1'b1;
      TRAP:    busy   = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal_op = (r_state == TRAP);
`endif

endmodule

// File: tb/tb_cu_seq.sv
// Self-checking bench for cu_seq: directed scenarios plus randomized instruction
// streams checked cycle by cycle against a trace model built from the phase rules.
module tb_cu_seq;

  typedef struct packed {
    logic       instr_ready;
    logic       alu_c_in;
    logic       alu_enable;
    logic [3:0] alu_sel;
    logic       reg_read_a;
    logic       reg_read_b;
    logic       reg_write;
    logic       reg_reset;
    logic [1:0] inst_type;
    logic [2:0] wb_sel;
    logic       pc_inc;
    logic       busy;
    logic       halted;
    logic       exec_timeout;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       alu_done = 1'b0;
  logic       instr_ready, alu_c_in, alu_enable, reg_read_a, reg_read_b;
  logic       reg_write, reg_reset, pc_inc, busy, halted, exec_timeout;
  logic [3:0] alu_sel;
  logic [1:0] inst_type;
  logic [2:0] wb_sel;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  out_t exp_q[$];
  bit   exp_trap;

  cu_seq dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .alu_done     (alu_done),
    .alu_c_in     (alu_c_in),
    .alu_enable   (alu_enable),
    .alu_sel      (alu_sel),
    .reg_read_a   (reg_read_a),
    .reg_read_b   (reg_read_b),
    .reg_write    (reg_write),
    .reg_reset    (reg_reset),
    .inst_type    (inst_type),
    .wb_sel       (wb_sel),
    .pc_inc       (pc_inc),
    .busy         (busy),
    .halted       (halted),
    .exec_timeout (exec_timeout)
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    .illegal_op   (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o = '{instr_ready, alu_c_in, alu_enable, alu_sel, reg_read_a, reg_read_b, reg_write,
          reg_reset, inst_type, wb_sel, pc_inc, busy, halted, exec_timeout};
    return o;
  endfunction

  function automatic out_t idle_fetch();
    out_t o;
    o = '0;
    o.instr_ready = 1'b1;
    return o;
  endfunction

  // Expected per-cycle outputs after the accept edge. n = EXEC cycle of alu_done for MUL
  // (1..16), anything else means alu_done never arrives.
  function automatic void build_trace(input logic [5:0] op, input int n);
    out_t o;
    bit is_r, is_mul, is_ill, done_ok;
    int ex;
    is_r    = (op >= 6'd1) && (op <= 6'd6);
    is_mul  = (op == 6'd6);
    is_ill  = !(op <= 6'd6 || op == 6'd14 || op == 6'd15 || op == 6'd63);
    done_ok = (n >= 1) && (n <= 16);
    exp_q.delete();
    exp_trap = 1'b0;
    o = '0;
    o.busy = 1'b1;
    o.reg_read_a = is_r;
    o.reg_read_b = is_r;
    exp_q.push_back(o);
    if (op == 6'd63) begin
      o = '0;
      o.halted = 1'b1;
      repeat (50) exp_q.push_back(o);
      return;
    end
`ifdef CU_ILLEGAL_TRAP_EN
    if (is_ill) begin
      exp_trap = 1'b1;
      o = '0;
      o.busy = 1'b1;
      repeat (6) exp_q.push_back(o);
      return;
    end
`endif
    if (is_r) begin
      ex = is_mul ? (done_ok ? n : 16) : 1;
      o = '0;
      o.busy = 1'b1;
      o.alu_enable = 1'b1;
      o.alu_sel = 4'(op - 6'd1);
      o.alu_c_in = (op == 6'd2);
      o.inst_type = 2'b01;
      o.reg_read_a = 1'b1;
      o.reg_read_b = 1'b1;
      repeat (ex) exp_q.push_back(o);
      if (is_mul && !done_ok) begin
        o = idle_fetch();
        o.exec_timeout = 1'b1;
        exp_q.push_back(o);
        exp_q.push_back(idle_fetch());
        return;
      end
    end
    o = '0;
    o.busy = 1'b1;
    o.pc_inc = 1'b1;
    if (is_r) begin
      o.reg_write = 1'b1;
      o.inst_type = 2'b01;
    end else if (op == 6'd14) begin
      o.reg_write = 1'b1;
      o.wb_sel = 3'b001;
      o.inst_type = 2'b10;
    end else if (op == 6'd15) begin
      o.reg_reset = 1'b1;
    end
    exp_q.push_back(o);
    exp_q.push_back(idle_fetch());
  endfunction

  task automatic check(input string tag, input int cyc, input out_t e);
    out_t got;
    got = sample();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s cyc %0d observed %h expected %h", tag, cyc, got, e);
    end
`ifdef CU_ILLEGAL_TRAP_EN
    vectors++;
    assert (illegal_op === (exp_trap && cyc >= 2)) else begin
      miscompares++;
      $error("FAIL %s_illegal cyc %0d observed %b expected %b", tag, cyc, illegal_op,
             exp_trap && cyc >= 2);
    end
`endif
  endtask

  // Precondition: #1 after a rising edge with the DUT idle in FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input int n);
    out_t e;
    build_trace(op, n);
    opcode = op;
    instr_valid = 1'b1;
    alu_done = 1'($urandom);
    exp_trap = 1'b0;
    check(tag, 0, idle_fetch());
    build_trace(op, n);
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(posedge clk);
      #1;
      e = exp_q[k-1];
      instr_valid = e.halted ? 1'b1 : (e.instr_ready ? 1'b0 : 1'($urandom));
      opcode = 6'($urandom);
      alu_done = (op == 6'd6) ? (k == n + 1) : 1'($urandom);
      check(tag, k, e);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    exp_trap = 1'b0;
    instr_valid = 1'b1;
    #1;
    check(tag, 0, idle_fetch());
    @(posedge clk);
    #1;
    rst = 1'b0;
    instr_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] pick [10];
    logic [5:0] op;
    int n;
    pick = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd14, 6'd15, 6'd0, 6'd42};

    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, idle_fetch());
    rst = 1'b0;

    run_instr("add", 6'd1, 0);
    run_instr("sub", 6'd2, 0);
    run_instr("ldim", 6'd14, 0);
    run_instr("mul_done5", 6'd6, 5);
    run_instr("mul_timeout", 6'd6, 0);
    run_instr("mul_done16", 6'd6, 16);
    run_instr("mul_done1", 6'd6, 1);
    run_instr("clr", 6'd15, 0);
    run_instr("nop", 6'd0, 0);
    run_instr("illegal", 6'b101010, 0);
`ifdef CU_ILLEGAL_TRAP_EN
    do_reset("trap_reset");
`endif

    // reset mid-EXEC of a MUL must clear every output asynchronously
    opcode = 6'd6;
    instr_valid = 1'b1;
    alu_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
    do_reset("rst_mid_exec");
    run_instr("add_after_rst", 6'd1, 0);

    for (int i = 0; i < 40; i++) begin
`ifdef CU_ILLEGAL_TRAP_EN
      op = pick[$urandom_range(0, 8)];
`else
      op = pick[$urandom_range(0, 9)];
`endif
      n = $urandom_range(0, 18);
      run_instr("random", op, n);
    end

    run_instr("halt", 6'd63, 0);
    do_reset("halt_reset");
    run_instr("add_after_halt", 6'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
- Multi-cycle control sequencer; next generation of the combinational opcode decoder.
- Latches an opcode through a valid/ready handshake, then steps FETCH -> DECODE -> EXEC -> WB.
- Asserts register-file, ALU and writeback controls in the correct phase, and waits on a multi-cycle ALU op with a timeout.
- Sits between instruction fetch and the datapath (register file, ALU, writeback mux).

Parameters:
- OPCODE_W, 6, opcode width; opcodes are zero-extended from the 6-bit encodings below.
- ALU_SEL_W, 4, width of alu_sel.
- WB_SEL_W, 3, width of wb_sel.
- MUL_TIMEOUT, 16, maximum EXEC cycles waiting for alu_done; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  opcode presented
- instr_ready  out  1  sequencer accepts opcode this cycle
- opcode  in  OPCODE_W  instruction opcode
- alu_done  in  1  multi-cycle ALU result ready
- alu_c_in  out  1  ALU carry in
- alu_enable  out  1  ALU active
- alu_sel  out  ALU_SEL_W  ALU function
- reg_read_a  out  1  read port A enable
- reg_read_b  out  1  read port B enable
- reg_write  out  1  register write strobe
- reg_reset  out  1  register-file clear strobe
- inst_type  out  2  00 none, 01 R-type, 10 immediate
- wb_sel  out  WB_SEL_W  000 ALU, 001 immediate
- pc_inc  out  1  one-cycle PC advance pulse
- busy  out  1  high in any state except FETCH and HALT
- halted  out  1  HALT state
- exec_timeout  out  1  one-cycle pulse on MUL timeout

Behaviour:
- Output timing: all outputs are decoded from the registered state and registered opcode; there is no combinational path from opcode to any output.
- Reset (asynchronous, any state, mid-instruction included):
  - state = FETCH, opcode register = NOP, timeout counter = 0.
  - Every output is 0 except instr_ready = 1.
- Opcode encodings (opcode -> alu_sel, alu_c_in, inst_type, wb_sel):
  - ADD 000001 -> 0000, 0, 01, 000
  - SUB 000010 -> 0001, 1, 01, 000
  - AND 000011 -> 0010, 0, 01, 000
  - OR 000100 -> 0011, 0, 01, 000
  - XOR 000101 -> 0100, 0, 01, 000
  - MUL 000110 -> 0101, 0, 01, 000
  - LDIM 001110 -> immediate, wb_sel 001
  - CLR 001111 -> register-file clear
  - HLT 111111 -> halt
  - Anything else -> NOP.
- FETCH:
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch opcode, go to DECODE. Otherwise hold.
- DECODE (1 cycle):
  - R-type: reg_read_a = reg_read_b = 1, then EXEC.
  - LDIM, CLR, NOP: go directly to WB.
  - HLT: go to HALT.
- EXEC:
  - alu_enable = 1; alu_sel, alu_c_in and inst_type driven; reg_read_a/b held at 1.
  - Single-cycle ops: 1 cycle, then WB.
  - MUL: count cycles in EXEC.
    - alu_done = 1 -> WB.
    - Count reaches MUL_TIMEOUT without alu_done -> exec_timeout pulse, go to FETCH with no write and no pc_inc.
    - alu_done in the same cycle as the timeout: alu_done wins.
- WB (1 cycle), pc_inc = 1 in all cases:
  - R-type: reg_write = 1, wb_sel = 000.
  - LDIM: reg_write = 1, wb_sel = 001, inst_type = 10.
  - CLR: reg_reset = 1, reg_write = 0.
  - NOP: no write.
  - Then FETCH.
- HALT:
  - halted = 1, instr_ready = 0.
  - Held until rst; instr_valid is ignored.
- Latency (accept cycle = 0):
  - Single-cycle ALU op: WB at cycle 3, next accept at cycle 4.
  - LDIM, CLR, NOP: WB at cycle 2, next accept at cycle 3.
  - MUL: WB at 2 + N, where N = cycles until alu_done.
- alu_done outside EXEC-MUL is ignored.
- inst_type, alu_sel, wb_sel, alu_c_in read 0 in FETCH and HALT.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode goes DECODE -> TRAP.
  - In TRAP: extra output illegal_op = 1, sticky; instr_ready = 0; busy = 1; no pc_inc.
  - Cleared only by rst.
- Undefined:
  - No illegal_op port; undefined opcodes execute as NOP (WB with pc_inc only).

Decomposition:
- cu_pkg holds:
  - opcode localparams;
  - typedef enum state_t {FETCH, DECODE, EXEC, WB, HALT, TRAP};
  - alu_sel constants;
  - inst_type and wb_sel enums;
  - packed struct ctrl_word_t (alu_sel, alu_c_in, inst_type, wb_sel, is_rtype, is_multi, is_ldim, is_clr, is_hlt, is_illegal).
- Sub-module cu_decode: purely combinational, opcode -> ctrl_word_t, instantiated on the registered opcode.
- cu_seq itself holds the FSM, the timeout counter and phase gating.

Test Plan:
- Reset release, ADD 000001 presented with instr_valid -> reg_read_a/b at cycle 1; alu_enable = 1, alu_sel = 0000 at cycle 2; reg_write = 1, pc_inc = 1 at cycle 3; instr_ready = 1 at cycle 4.
- SUB -> alu_c_in = 1 and alu_sel = 0001 during EXEC only. LDIM -> no alu_enable; reg_write = 1, wb_sel = 001 at cycle 2.
- MUL with alu_done at EXEC cycle 5 -> WB at cycle 7. MUL with alu_done never asserted -> exec_timeout pulse after 16 EXEC cycles, no reg_write, no pc_inc, back to FETCH.
- CLR -> reg_reset = 1 for exactly 1 cycle, reg_write = 0. HLT -> halted = 1, instr_ready = 0, held for 50 cycles of instr_valid = 1.
- rst asserted mid-EXEC of MUL -> all outputs 0 immediately, instr_ready = 1; the next ADD runs with normal timing.
- Opcode 101010 -> NOP WB with only pc_inc when CU_ILLEGAL_TRAP_EN is undefined; with it defined -> illegal_op = 1 sticky, instr_ready = 0.
